// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller.
// Optional build macro: PONG_WIN_BY_TWO_EN (win requires a two-point lead).
package pong_pkg;

    // Match phase encodings, visible on the state output
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Winner codes
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // serve_dir values: which player the ball is served toward
    localparam logic SERVE_TO_P1 = 1'b0;
    localparam logic SERVE_TO_P2 = 1'b1;

    // True when a player holding score s against opponent score o has won.
    // The hard cap always wins so a long deuce can never stall the match.
    function automatic logic has_won(input int s, input int o, input int max_s,
                                     input int cap, input logic by_two);
        if (by_two)
            return (s == cap) || ((s >= max_s) && (s >= o + 2));
        else
            return (s >= max_s);
    endfunction

endpackage

// File: rtl/pong_tick_counter.sv
// Tick-gated down-counter: load has priority, then each tick decrements
// until zero. Shared by the SERVE delay and the OVER hold-off.
module pong_tick_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] r_count;

    // Load wins over tick, so a tick on the loading edge is never counted
    always_ff @(posedge clock) begin
        if (reset)
            r_count <= '0;
        else if (load)
            r_count <= load_value;
        else if (tick && (r_count != '0))
            r_count <= r_count - CNT_W'(1);
    end

    assign count = r_count;
    assign done  = (r_count == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: scores, serve/play/point/over sequencing and ball
// motion gating. All phase timing advances on the game-rate tick strobe.
// Optional build macro: PONG_WIN_BY_TWO_EN (win needs MAX_SCORE and a lead
// of two, or reaching the score cap).
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int MAX_SCORE   = 10,
    parameter int SCORE_W     = 5,
    parameter int SERVE_TICKS = 30,
    parameter int OVER_TICKS  = 90
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               miss_1,
    input  logic               miss_2,
    output logic               ball_run,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_1,
    output logic [SCORE_W-1:0] score_2,
    output logic [2:0]         state,
    output logic [1:0]         winner,
    output logic               point_pulse
);

    localparam int MAX_T = (SERVE_TICKS > OVER_TICKS) ? SERVE_TICKS : OVER_TICKS;
    localparam int CNT_W = (MAX_T < 2) ? 1 : $clog2(MAX_T + 1);
    localparam logic [SCORE_W-1:0] SCORE_CAP = '1;

`ifdef PONG_WIN_BY_TWO_EN
    localparam logic WIN_BY_TWO = 1'b1;
`else
    localparam logic WIN_BY_TWO = 1'b0;
`endif

    state_e             r_state;
    logic [SCORE_W-1:0] r_score_1, r_score_2;
    logic [1:0]         r_winner;
    logic               r_serve_dir;
    logic               r_ball_run;
    logic               r_ball_reset;
    logic               r_point_pulse;

    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_cnt_done;
    logic               w_p1_wins, w_p2_wins;
    logic               w_serve_last;
    logic [SCORE_W-1:0] w_s1_inc, w_s2_inc;

    // Saturating increments: scores stick at the cap instead of wrapping
    assign w_s1_inc = (r_score_1 == SCORE_CAP) ? r_score_1 : r_score_1 + SCORE_W'(1);
    assign w_s2_inc = (r_score_2 == SCORE_CAP) ? r_score_2 : r_score_2 + SCORE_W'(1);

    // Win decision uses the scores already registered on entry to POINT
    assign w_p1_wins = has_won(int'(r_score_1), int'(r_score_2), MAX_SCORE,
                               int'(SCORE_CAP), WIN_BY_TWO);
    assign w_p2_wins = has_won(int'(r_score_2), int'(r_score_1), MAX_SCORE,
                               int'(SCORE_CAP), WIN_BY_TWO);

    // Last serve tick: count at one (or zero for a degenerate zero delay)
    assign w_serve_last = tick && (w_cnt <= CNT_W'(1));

    // Counter loads on every entry to SERVE or OVER, mirroring FSM transitions
    always_comb begin
        w_load     = 1'b0;
        w_load_val = CNT_W'(SERVE_TICKS);
        case (r_state)
            ST_IDLE:  w_load = start;
            ST_PLAY:  w_load = miss_1 && miss_2;
            ST_POINT: begin
                w_load = 1'b1;
                if (w_p1_wins || w_p2_wins)
                    w_load_val = CNT_W'(OVER_TICKS);
            end
            ST_OVER:  w_load = start && w_cnt_done;
            default:  w_load = 1'b0;
        endcase
    end

    pong_tick_counter #(
        .CNT_W(CNT_W)
    ) u_tick_cnt (
        .clock      (clock),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_load_val),
        .tick       (tick),
        .count      (w_cnt),
        .done       (w_cnt_done)
    );

    // Match FSM with registered outputs; pulses default low every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_score_1     <= '0;
            r_score_2     <= '0;
            r_winner      <= WIN_NONE;
            r_serve_dir   <= SERVE_TO_P1;
            r_ball_run    <= 1'b0;
            r_ball_reset  <= 1'b0;
            r_point_pulse <= 1'b0;
        end else begin
            r_ball_reset  <= 1'b0;
            r_point_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_score_1 <= '0;
                    r_score_2 <= '0;
                    r_winner  <= WIN_NONE;
                    if (start) begin
                        r_state      <= ST_SERVE;
                        r_serve_dir  <= SERVE_TO_P1;
                        r_ball_reset <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (w_serve_last) begin
                        r_state    <= ST_PLAY;
                        r_ball_run <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (miss_1 && miss_2) begin
                        // Simultaneous misses: replay the serve, nobody scores
                        r_state      <= ST_SERVE;
                        r_ball_run   <= 1'b0;
                        r_ball_reset <= 1'b1;
                    end else if (miss_1) begin
                        r_score_2     <= w_s2_inc;
                        r_serve_dir   <= SERVE_TO_P1;
                        r_point_pulse <= 1'b1;
                        r_ball_run    <= 1'b0;
                        r_state       <= ST_POINT;
                    end else if (miss_2) begin
                        r_score_1     <= w_s1_inc;
                        r_serve_dir   <= SERVE_TO_P2;
                        r_point_pulse <= 1'b1;
                        r_ball_run    <= 1'b0;
                        r_state       <= ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (w_p1_wins) begin
                        r_state  <= ST_OVER;
                        r_winner <= WIN_P1;
                    end else if (w_p2_wins) begin
                        r_state  <= ST_OVER;
                        r_winner <= WIN_P2;
                    end else begin
                        r_state      <= ST_SERVE;
                        r_ball_reset <= 1'b1;
                    end
                end
                ST_OVER: begin
                    if (start && w_cnt_done) begin
                        r_state      <= ST_SERVE;
                        r_score_1    <= '0;
                        r_score_2    <= '0;
                        r_winner     <= WIN_NONE;
                        r_serve_dir  <= SERVE_TO_P1;
                        r_ball_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ball_run <= 1'b0;
                end
            endcase
        end
    end

    assign ball_run    = r_ball_run;
    assign ball_reset  = r_ball_reset;
    assign serve_dir   = r_serve_dir;
    assign score_1     = r_score_1;
    assign score_2     = r_score_2;
    assign state       = r_state;
    assign winner      = r_winner;
    assign point_pulse = r_point_pulse;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a phase-level reference model pushes
// the expected post-edge outputs for every driven cycle; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_pong_match_ctrl;

    localparam int MAX_SCORE   = 3;
    localparam int SCORE_W     = 5;
    localparam int SERVE_TICKS = 2;
    localparam int OVER_TICKS  = 2;
    localparam int CAP         = 31;

    localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_POINT = 3, P_OVER = 4;

    logic clock = 1'b0;
    logic reset = 1'b1, tick = 1'b0, start = 1'b0, miss_1 = 1'b0, miss_2 = 1'b0;
    logic ball_run, ball_reset, serve_dir, point_pulse;
    logic [SCORE_W-1:0] score_1, score_2;
    logic [2:0] state;
    logic [1:0] winner;

    pong_match_ctrl #(
        .MAX_SCORE(MAX_SCORE), .SCORE_W(SCORE_W),
        .SERVE_TICKS(SERVE_TICKS), .OVER_TICKS(OVER_TICKS)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .start(start),
        .miss_1(miss_1), .miss_2(miss_2),
        .ball_run(ball_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
        .score_1(score_1), .score_2(score_2), .state(state),
        .winner(winner), .point_pulse(point_pulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        int ph; int s1; int s2; int sd; int win; int brst; int pp; int run;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: phase, scores and ticks seen in the current phase
    int m_ph = P_IDLE, m_s1 = 0, m_s2 = 0, m_sd = 0, m_win = 0;
    int m_brst = 0, m_pp = 0, m_seen = 0;

    function automatic bit won(int s, int o);
`ifdef PONG_WIN_BY_TWO_EN
        return (s == CAP) || (s >= MAX_SCORE && s - o >= 2);
`else
        return s >= MAX_SCORE;
`endif
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Advance the model by one clock edge with the given sampled inputs
    task automatic model(bit r, bit t, bit s, bit m1, bit m2);
        if (r) begin
            m_ph = P_IDLE; m_s1 = 0; m_s2 = 0; m_sd = 0; m_win = 0;
            m_brst = 0; m_pp = 0; m_seen = 0;
            return;
        end
        m_brst = 0; m_pp = 0;
        case (m_ph)
            P_IDLE: if (s) begin
                m_ph = P_SERVE; m_sd = 0; m_brst = 1; m_seen = 0;
            end
            P_SERVE: if (t) begin
                m_seen++;
                if (m_seen >= SERVE_TICKS) m_ph = P_PLAY;
            end
            P_PLAY: begin
                if (m1 && m2) begin
                    m_ph = P_SERVE; m_brst = 1; m_seen = 0;
                end else if (m1) begin
                    m_s2 = (m_s2 < CAP) ? m_s2 + 1 : CAP;
                    m_sd = 0; m_pp = 1; m_ph = P_POINT;
                end else if (m2) begin
                    m_s1 = (m_s1 < CAP) ? m_s1 + 1 : CAP;
                    m_sd = 1; m_pp = 1; m_ph = P_POINT;
                end
            end
            P_POINT: begin
                if (won(m_s1, m_s2)) begin
                    m_ph = P_OVER; m_win = 1; m_seen = 0;
                end else if (won(m_s2, m_s1)) begin
                    m_ph = P_OVER; m_win = 2; m_seen = 0;
                end else begin
                    m_ph = P_SERVE; m_brst = 1; m_seen = 0;
                end
            end
            default: begin
                if (s && m_seen >= OVER_TICKS) begin
                    m_ph = P_SERVE; m_s1 = 0; m_s2 = 0; m_win = 0;
                    m_sd = 0; m_brst = 1; m_seen = 0;
                end else if (t && m_seen < OVER_TICKS) begin
                    m_seen++;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs and record what the DUT must show after the edge
    task automatic step(bit r, bit t, bit s, bit m1, bit m2);
        exp_t e;
        @(negedge clock);
        #1;
        reset = r; tick = t; start = s; miss_1 = m1; miss_2 = m2;
        model(r, t, s, m1, m2);
        e.ph = m_ph; e.s1 = m_s1; e.s2 = m_s2; e.sd = m_sd; e.win = m_win;
        e.brst = m_brst; e.pp = m_pp; e.run = (m_ph == P_PLAY) ? 1 : 0;
        q.push_back(e);
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0);
    endtask

    // Reach PLAY via the model's own phase; an expired bound is a failure
    task automatic to_play();
        int k;
        for (k = 0; k < 40; k++) begin
            if (m_ph == P_PLAY) break;
            step(0, 1, (m_ph == P_IDLE || m_ph == P_OVER), 0, 0);
        end
        n_chk++;
        if (m_ph != P_PLAY) begin
            n_fail++;
            $display("FAIL to_play_timeout cycle %0d: phase %0d expected %0d", cyc, m_ph, P_PLAY);
        end
    endtask

    // Score one point from PLAY then let POINT resolve
    task automatic point(bit m1, bit m2);
        to_play();
        step(0, 0, 0, m1, m2);
        idle_step();
    endtask

    // Sample right after the edge the last step was driven for
    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every falling edge, compare DUT outputs with the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",       int'(state),       e.ph);
            chk("score_1",     int'(score_1),     e.s1);
            chk("score_2",     int'(score_2),     e.s2);
            chk("serve_dir",   int'(serve_dir),   e.sd);
            chk("winner",      int'(winner),      e.win);
            chk("ball_reset",  int'(ball_reset),  e.brst);
            chk("point_pulse", int'(point_pulse), e.pp);
            chk("ball_run",    int'(ball_run),    e.run);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        repeat (3) step(1, 0, 0, 0, 0);
        repeat (2) idle_step();
        step(0, 1, 0, 1, 1);                 // misses ignored in IDLE
        step(0, 0, 1, 0, 0);                 // start -> SERVE with ball_reset
        settle();
        chk("start_to_serve", int'(state), 1);
        chk("start_ball_reset", int'(ball_reset), 1);
        step(0, 0, 0, 1, 0);                 // miss during SERVE ignored
        to_play();
        settle();
        chk("play_ball_run", int'(ball_run), 1);

        // Three points to player 1 with a double miss replay between them
        point(0, 1);
        to_play();
        step(0, 0, 0, 1, 1);                 // double miss -> SERVE, no score
        point(0, 1);
        point(0, 1);
        settle();
        chk("p1_win_winner", int'(winner), 1);
        chk("p1_win_score", int'(score_1), 3);

        // OVER hold-off: early start ignored, later start accepted
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        settle();
        chk("over_early_start", int'(state), 4);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        settle();
        chk("over_restart_state", int'(state), 1);
        chk("over_restart_winner", int'(winner), 0);

        // 3-2 (match end without win-by-two), then 4-2 if the game continues
        point(0, 1); point(0, 1); point(1, 0); point(1, 0); point(0, 1);
        if (m_ph != P_OVER) point(0, 1);

        // Reset in PLAY at 2-1
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        point(0, 1); point(0, 1); point(1, 0);
        to_play();
        step(1, 0, 0, 0, 0);
        settle();
        chk("reset_in_play", int'(state), 0);
        chk("reset_scores", int'(score_1) + int'(score_2), 0);

        // Randomized play
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        idle_step();

        // Drain the scoreboard
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clock);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
